// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan scheduler with anti-ghost blanking, blink masks
// and a shadow/active digit store that only swaps at frame boundaries.
module seg_scan_ctrl #(
    parameter int DWELL        = 262144,
    parameter int BLANK        = 4096,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_digit,
    input  logic [3:0] wr_code,
    input  logic       wr_on,
    input  logic       wr_blink,
    input  logic       commit,
    output logic       commit_pending,
    output logic [7:0] an,
    output logic [3:0] data,
    output logic [2:0] scan_digit,
    output logic       frame_start
);

    localparam int DW = $clog2(DWELL);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DWELL - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [DW:0]   BLANK_V   = (DW + 1)'(BLANK);

    logic [DW-1:0] dcnt;
    logic [2:0]    dig;
    logic [BW-1:0] bcnt;
    logic          blink_phase;
    logic          run;

    // entry layout: {code[3:0], on, blink}
    logic [5:0] shadow [8];
    logic [5:0] active [8];

    logic       dcnt_wrap;
    logic       boundary;
    logic [5:0] cur;
    logic       blank;

    always_comb begin
        dcnt_wrap = (dcnt == DCNT_LAST);
        boundary  = dcnt_wrap && (dig == 3'd7);
        cur       = active[dig];
        blank     = ({1'b0, dcnt} < BLANK_V) || !cur[1] || (cur[0] && !blink_phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt           <= '0;
            dig            <= '0;
            bcnt           <= '0;
            blink_phase    <= 1'b1;
            run            <= 1'b0;
            commit_pending <= 1'b0;
            an             <= 8'hFF;
            data           <= '0;
            scan_digit     <= '0;
            frame_start    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            run  <= 1'b1;
            dcnt <= dcnt_wrap ? '0 : dcnt + DW'(1);
            if (dcnt_wrap)
                dig <= dig + 3'd1;

            if (boundary) begin
                if (bcnt == BCNT_LAST) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end

            if (wr_en)
                shadow[wr_digit] <= {wr_code, wr_on, wr_blink};

            // Copy reads shadow before any same-cycle write lands.
            if (boundary && (commit_pending || commit)) begin
                for (int i = 0; i < 8; i++)
                    active[i] <= shadow[i];
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end

            an          <= blank ? 8'hFF : ~(8'h01 << dig);
            data        <= cur[5:2];
            scan_digit  <= dig;
            // run masks the (0,0) state that follows reset release
            frame_start <= run && (dig == 3'd0) && (dcnt == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected outputs come from a time-indexed
// display model and are queued per cycle, then compared after the clock edge.
module tb_seg_scan_ctrl;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DWELL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_digit = '0;
    logic [3:0] wr_code = '0;
    logic       wr_on = 1'b0;
    logic       wr_blink = 1'b0;
    logic       commit = 1'b0;
    logic       commit_pending;
    logic [7:0] an;
    logic [3:0] data;
    logic [2:0] scan_digit;
    logic       frame_start;

    seg_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_digit(wr_digit), .wr_code(wr_code),
        .wr_on(wr_on), .wr_blink(wr_blink), .commit(commit),
        .commit_pending(commit_pending), .an(an), .data(data),
        .scan_digit(scan_digit), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [3:0] data;
        logic [2:0] scan;
        logic       fs;
        logic       pend;
    } exp_t;

    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   k = 0;
    logic [5:0] m_sh  [8];
    logic [5:0] m_act [8];
    logic       m_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        exp_t       e;
        int         dc, dg;
        logic [5:0] ent;
        logic       vis, blank;
        logic [7:0] one;
        one = 8'h01;
        if (rst) begin
            e = '{an: 8'hFF, data: 4'h0, scan: 3'd0, fs: 1'b0, pend: 1'b0};
            for (int i = 0; i < 8; i++) begin
                m_sh[i]  = '0;
                m_act[i] = '0;
            end
            m_pend = 1'b0;
            k = 0;
        end else begin
            dc    = k % DWELL;
            dg    = (k / DWELL) % 8;
            ent   = m_act[dg];
            vis   = (((k / FRAME) / BF) % 2) == 0;
            blank = (dc < BLANK) || !ent[1] || (ent[0] && !vis);
            e.an   = blank ? 8'hFF : ~(one << dg);
            e.data = ent[5:2];
            e.scan = 3'(dg);
            e.fs   = (k % FRAME == 0) && (k != 0);
            if ((k % FRAME == FRAME - 1) && (m_pend || commit)) begin
                for (int i = 0; i < 8; i++)
                    m_act[i] = m_sh[i];
                m_pend = 1'b0;
            end else if (commit) begin
                m_pend = 1'b1;
            end
            if (wr_en)
                m_sh[wr_digit] = {wr_code, wr_on, wr_blink};
            e.pend = m_pend;
            k++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("an", 32'(an), 32'(e.an));
        check("data", 32'(data), 32'(e.data));
        check("scan_digit", 32'(scan_digit), 32'(e.scan));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("commit_pending", 32'(commit_pending), 32'(e.pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic align(input int pos);
        int guard;
        guard = 0;
        while ((k % FRAME) != pos && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
    endtask

    task automatic wr(input int d, input int code, input logic on, input logic bl);
        wr_en    = 1'b1;
        wr_digit = 3'(d);
        wr_code  = 4'(code);
        wr_on    = on;
        wr_blink = bl;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        run(3);
        rst = 1'b0;

        // Full display, codes equal to digit index
        for (int d = 0; d < 8; d++)
            wr(d, d, 1'b1, 1'b0);
        do_commit();
        run(3 * FRAME);

        // Tear-free update of digit 3: 5 shown, 9 held in shadow until commit
        wr(3, 5, 1'b1, 1'b0);
        do_commit();
        run(2 * FRAME);
        align(20);
        wr(3, 9, 1'b1, 1'b0);
        run(2 * FRAME);
        do_commit();
        run(2 * FRAME);

        // Commit and write on the boundary cycle: copy sees the old shadow
        align(FRAME - 1);
        commit   = 1'b1;
        wr_en    = 1'b1;
        wr_digit = 3'd0;
        wr_code  = 4'hA;
        wr_on    = 1'b1;
        wr_blink = 1'b0;
        tick();
        commit = 1'b0;
        wr_en  = 1'b0;
        run(FRAME + 5);
        do_commit();
        run(2 * FRAME);

        // Blink on digit 2
        wr(2, 2, 1'b1, 1'b1);
        do_commit();
        run(5 * FRAME);

        // Digit 7 disabled
        wr(7, 7, 1'b0, 1'b0);
        do_commit();
        run(2 * FRAME);

        // Reset with a commit pending mid-frame
        align(20);
        wr(4, 3, 1'b1, 1'b0);
        do_commit();
        run(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
